dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 32x32 data memory (async read, write on posedge clk) between two requesters:
//  port 0 (CPU load/store) and port 1 (loader/debug).
//  Round-robin arbitration with a req/ack handshake.
//  Read data is registered, so each requester sees a clean one-cycle ack with its data.
//  Sits between the requesters and the memory's we/a/wd/rd pins.
// PARAMETERS
//  ADDR_W  5   word-address width (32 words)
//  DATA_W  32  data word width
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       synchronous, active-high
//  m0_req     in   1       port 0 request; hold with m0_we/m0_a/m0_wd stable until m0_ack
//  m0_we      in   1       port 0: 1=write, 0=read
//  m0_a       in   ADDR_W  port 0 word address
//  m0_wd      in   DATA_W  port 0 write data
//  m0_ack     out  1       port 0 one-cycle completion pulse
//  m0_rd      out  DATA_W  port 0 read data, valid while m0_ack=1
//  m1_*       same set as m0_* for port 1
//  mem_we     out  1       memory write enable
//  mem_a      out  ADDR_W  memory address
//  mem_wd     out  DATA_W  memory write data
//  mem_rd     in   DATA_W  memory combinational read data
// BEHAVIOUR
//  Reset:
//   - state=IDLE, last=1 (port 0 wins first tie)
//   - m0_ack=m1_ack=0, m0_rd=m1_rd=0, mem_we=0
//   - mem_a/mem_wd driven 0 when not in GRANT
//  FSM:
//   - IDLE: if any req -> GRANT; gnt = picked port; last <= gnt.
//   - GRANT (1 cycle): mem_a/mem_we/mem_wd driven from the gnt port; mem_we = gnt_we & ~reset.
//     At the edge: gnt_ack <= 1, gnt_rd <= mem_rd (for writes, mem_rd as read at that address),
//     then -> DONE.
//   - DONE (ack cycle): the served port's req is ignored, because the requester drops it at this edge.
//     If the other port's req=1 -> GRANT it directly; otherwise -> IDLE. Acks clear.
//  Pick rule: only one req -> that port. Both -> the port != last.
//  Latency: req seen in IDLE -> ack 2 cycles later. Best throughput is 1 access per 2 cycles
//  when both alternate; a single port gets 1 access per 3 cycles.
//  Boundaries:
//   - Never two acks in the same cycle; never a write outside GRANT.
//   - Req dropped before ack: protocol violation. The access still completes and acks.
//   - Reset in any state: the next cycle is IDLE with outputs at reset values. A write in a cycle
//     with reset=1 is suppressed.
//   - Address wraps naturally (ADDR_W bits); no range check.
// CONFIGURATION
//  DMEM_ARB_FIXED_PRIO_EN
//   - defined: fixed priority; port 0 always wins when both request, and `last` is unused.
//     Port 1 can starve.
//   - undefined: round-robin as above.
// STRUCTURE
//  dmem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, GRANT, DONE} arb_state_t
//   - localparams ADDR_W=5, DATA_W=32
//  Sub-module dmem_arb_pick: combinational 2-way picker (req0, req1, last, exclude) -> gnt, any.
//   - Holds the macro switch.
//  Top: FSM, gnt/last regs, output mux, registered ack/rd.
// TESTING
//  1. Reset held 2 cycles, then released.
//     -> all acks 0, mem_we 0, m0_rd=m1_rd=0 in the first post-reset cycle.
//  2. m0 write a=2, wd=0x55; then m0 read a=2.
//     -> mem_we=1 only in the GRANT cycle; read ack with m0_rd=0x55, 2 cycles after req.
//  3. m0 and m1 both request from reset (m0 rd a=4, m1 rd a=9; memory holds 0x00020007/0x00001043).
//     -> m0 acked first with 0x00020007, m1 next with 0x00001043, consecutive grants with no IDLE between.
//  4. Both hold req continuously for 10 accesses.
//     -> grants alternate 0,1,0,1 (fixed-prio build: all to port 0).
//  5. Reset asserted during GRANT of an m1 write to a=7 (old 0x44), wd=0xFF.
//     -> no write occurs, a=7 still reads 0x44, no ack, state IDLE.
//  6. m1 write a=31 then m1 read a=0 back-to-back.
//     -> each access acked exactly once, 3 cycles apart; no spurious re-grant in DONE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the two-port data-memory arbiter.
package dmem_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} arb_state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side (m0/m1) and memory-side pins of the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_a;
  logic [DATA_W-1:0] m0_wd;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rd;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_a;
  logic [DATA_W-1:0] m1_wd;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rd;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_a, m0_wd,
    output m0_ack, m0_rd,
    input  m1_req, m1_we, m1_a, m1_wd,
    output m1_ack, m1_rd,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output m0_req, m0_we, m0_a, m0_wd,
    input  m0_ack, m0_rd,
    output m1_req, m1_we, m1_a, m1_wd,
    input  m1_ack, m1_rd,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way request picker; DMEM_ARB_FIXED_PRIO_EN selects fixed priority
// (port 0 wins ties) instead of round-robin against `last`.
module dmem_arb_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic [1:0] exclude,
  output logic       gnt,
  output logic       any
);
  logic r0;
  logic r1;

  always_comb begin
    r0  = req0 & ~exclude[0];
    r1  = req1 & ~exclude[1];
    any = r0 | r1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    gnt = ~r0 & r1;
`else
    // On a tie the port that was not served last goes next.
    gnt = (r0 & r1) ? ~last : r1;
`endif
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port 32x32 data memory between two
// requesters; build with DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  arb_state_t        state;
  arb_state_t        state_n;
  logic              gnt;
  logic              gnt_n;
  logic              last;
  logic              last_n;
  logic              pick_gnt;
  logic              pick_any;
  logic [1:0]        exclude;
  logic              in_grant;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_wd;

  logic              ack0_p1;
  logic              ack1_p1;
  logic [DATA_W-1:0] rd0_p1;
  logic [DATA_W-1:0] rd1_p1;

  // The port just served still holds req during its ack cycle, so mask it.
  assign exclude  = (state == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign in_grant = (state == GRANT);

  dmem_arb_pick u_pick (
    .req0    (bus.m0_req),
    .req1    (bus.m1_req),
    .last    (last),
    .exclude (exclude),
    .gnt     (pick_gnt),
    .any     (pick_any)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          gnt_n   = pick_gnt;
          last_n  = pick_gnt;
        end
      end
      GRANT: state_n = DONE;
      DONE: begin
        if (pick_any) begin
          state_n = GRANT;
          gnt_n   = pick_gnt;
          last_n  = pick_gnt;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel_we = gnt ? bus.m1_we : bus.m0_we;
    sel_a  = gnt ? bus.m1_a  : bus.m0_a;
    sel_wd = gnt ? bus.m1_wd : bus.m0_wd;
  end

  assign bus.mem_we = in_grant & sel_we & ~reset;
  assign bus.mem_a  = in_grant ? sel_a  : '0;
  assign bus.mem_wd = in_grant ? sel_wd : '0;

  // GRANT -> DONE boundary: capture read data and raise the served port's ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      last    <= 1'b1;
      ack0_p1 <= 1'b0;
      ack1_p1 <= 1'b0;
      rd0_p1  <= '0;
      rd1_p1  <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      last    <= last_n;
      ack0_p1 <= in_grant & ~gnt;
      ack1_p1 <= in_grant & gnt;
      if (in_grant && !gnt) rd0_p1 <= bus.mem_rd;
      if (in_grant && gnt)  rd1_p1 <= bus.mem_rd;
    end
  end

  assign bus.m0_ack = ack0_p1;
  assign bus.m1_ack = ack1_p1;
  assign bus.m0_rd  = rd0_p1;
  assign bus.m1_rd  = rd1_p1;
endmodule
